// File: rtl/fpga_irq_aggregator.sv
// fpga_irq_aggregator
//   Collects up to NUM_SRC interrupt lines into sticky pending bits (level or
//   rising-edge capture per source), masks them and drives one registered irq
//   to the CPU. A 16-bit Avalon-MM slave exposes status, pending (W1C), mask,
//   active, highest-priority source, capture mode and a capture counter.
// Ports
//   clk, reset         : single clock, synchronous active-high reset
//   irq_in[NUM_SRC]    : source interrupt lines (same clock domain)
//   address[3]         : register word address
//   chipselect,write_n : write happens when chipselect && !write_n
//   writedata[16]      : write data
//   readdata[16]       : registered read data, 1-cycle latency, ignores chipselect
//   irq                : registered |(PENDING & MASK)
module fpga_irq_aggregator #(
   parameter int          NUM_SRC  = 8,
   parameter logic [15:0] EDGE_RST = 16'h0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   output logic               irq
);

   // Bits at or above NUM_SRC are forced to zero in every stored register.
   localparam logic [31:0] VALID32 = (32'd1 << NUM_SRC) - 32'd1;
   localparam logic [15:0] VALID   = VALID32[15:0];

   localparam logic [2:0] A_STATUS  = 3'd0;
   localparam logic [2:0] A_PENDING = 3'd1;
   localparam logic [2:0] A_MASK    = 3'd2;
   localparam logic [2:0] A_ACTIVE  = 3'd3;
   localparam logic [2:0] A_HIGHEST = 3'd4;
   localparam logic [2:0] A_EDGE    = 3'd5;
   localparam logic [2:0] A_COUNT   = 3'd6;

   logic [15:0] pending_q, pending_d;
   logic [15:0] mask_q, mask_d;
   logic [15:0] edge_sel_q, edge_sel_d;
   logic [15:0] count_q, count_d;
   logic [15:0] prev_q, prev_d;
   logic [15:0] readdata_q, readdata_d;
   logic        irq_q, irq_d;

   logic [15:0] in16, set, clr, active;
   logic [3:0]  idx;
   logic        wr, new_cap;

   always_comb begin
      in16 = '0;
      for (int i = 0; i < NUM_SRC; i++) in16[i] = irq_in[i];
   end

   assign wr     = chipselect & ~write_n;
   assign active = pending_q & mask_q;

   // Lowest set bit wins: scan downwards so the last hit is the lowest index.
   always_comb begin
      idx = '0;
      for (int i = 15; i >= 0; i--) if (active[i]) idx = 4'(i);
   end

   always_comb begin
      set     = ((edge_sel_q & in16 & ~prev_q) | (~edge_sel_q & in16)) & VALID;
      clr     = (wr && address == A_PENDING) ? writedata : 16'h0;
      // set is OR-ed after the clear so a simultaneous capture survives W1C
      pending_d = ((pending_q & ~clr) | set) & VALID;
      new_cap   = |(set & ~pending_q);
      prev_d    = in16;

      mask_d     = (wr && address == A_MASK) ? (writedata & VALID) : mask_q;
      edge_sel_d = (wr && address == A_EDGE) ? (writedata & VALID) : edge_sel_q;

      // Clear and increment in the same cycle leave the counter at 1.
      if (wr && address == A_COUNT)
         count_d = new_cap ? 16'h1 : 16'h0;
      else if (new_cap && count_q != 16'hFFFF)
         count_d = count_q + 16'h1;
      else
         count_d = count_q;

      irq_d = |active;

      case (address)
         A_STATUS:  readdata_d = in16;
         A_PENDING: readdata_d = pending_q;
         A_MASK:    readdata_d = mask_q;
         A_ACTIVE:  readdata_d = active;
         A_HIGHEST: readdata_d = {|active, 11'b0, idx};
         A_EDGE:    readdata_d = edge_sel_q;
         A_COUNT:   readdata_d = count_q;
         default:   readdata_d = 16'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q  <= '0;
         mask_q     <= '0;
         edge_sel_q <= EDGE_RST & VALID;
         count_q    <= '0;
         prev_q     <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         edge_sel_q <= edge_sel_d;
         count_q    <= count_d;
         prev_q     <= prev_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_fpga_irq_aggregator.sv
// Directed bench for fpga_irq_aggregator (NUM_SRC=8, EDGE_RST=16'h00A0).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_fpga_irq_aggregator;

   localparam logic [15:0] ERST = 16'h00A0;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  irq_in;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        irq;

   int total = 0;
   int bad   = 0;

   fpga_irq_aggregator #(.NUM_SRC(8), .EDGE_RST(ERST)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      idle();
   endtask

   task automatic rd(input logic [2:0] a, input string tag, input logic [15:0] exp);
      idle();
      address = a;
      tick();
      chk(tag, readdata, exp);
   endtask

   initial begin
      reset = 1'b1; irq_in = '0; address = '0; idle();
      tick(); tick();
      reset = 1'b0;

      // 1: reset state
      chk("rst_irq", {15'b0, irq}, 16'h0);
      for (int a = 0; a < 8; a++)
         rd(3'(a), $sformatf("rst_reg%0d", a), (a == 5) ? ERST : 16'h0);

      // 2: edge capture, irq latency, HIGHEST, COUNT, W1C
      wr(3'd2, 16'h0001);
      wr(3'd5, 16'h0001);
      irq_in = 8'h01;
      tick();
      irq_in = 8'h00;
      chk("t2_irq_lat1", {15'b0, irq}, 16'h0);
      tick();
      chk("t2_irq_lat2", {15'b0, irq}, 16'h1);
      rd(3'd1, "t2_pending", 16'h0001);
      rd(3'd4, "t2_highest", 16'h8000);
      rd(3'd6, "t2_count", 16'h0001);
      wr(3'd1, 16'h0001);
      chk("t2_irq_w1c_edge", {15'b0, irq}, 16'h1);
      tick();
      chk("t2_irq_cleared", {15'b0, irq}, 16'h0);
      rd(3'd4, "t2_highest0", 16'h0000);

      // 3: priority between bits 2 and 5
      wr(3'd5, 16'h0000);
      irq_in = 8'h24;
      tick();
      irq_in = 8'h00;
      wr(3'd2, 16'h0024);
      rd(3'd4, "t3_highest2", 16'h8002);
      wr(3'd1, 16'h0004);
      rd(3'd4, "t3_highest5", 16'h8005);
      rd(3'd3, "t3_active", 16'h0020);
      wr(3'd1, 16'h00FF);
      rd(3'd0, "t3_status0", 16'h0000);

      // 4: level mode, W1C has no lasting effect while the line is high
      wr(3'd2, 16'h0008);
      irq_in = 8'h08;
      tick(); tick();
      chk("t4_irq_on", {15'b0, irq}, 16'h1);
      wr(3'd1, 16'h0008);
      rd(3'd1, "t4_pend_held", 16'h0008);
      rd(3'd0, "t4_status", 16'h0008);
      chk("t4_irq_held", {15'b0, irq}, 16'h1);
      irq_in = 8'h00;
      tick();
      wr(3'd1, 16'h0008);
      rd(3'd1, "t4_pend_clr", 16'h0000);
      tick();
      chk("t4_irq_off", {15'b0, irq}, 16'h0);

      // 5: set beats clear; COUNT clear collides with a capture
      wr(3'd5, 16'h0002);
      irq_in = 8'h02;
      wr(3'd1, 16'h0002);
      irq_in = 8'h00;
      rd(3'd1, "t5_set_wins", 16'h0002);
      wr(3'd1, 16'h0002);
      irq_in = 8'h02;
      wr(3'd6, 16'h1234);
      irq_in = 8'h00;
      rd(3'd6, "t5_count_one", 16'h0001);
      // unused bits and read-only registers
      wr(3'd2, 16'hFFFF);
      rd(3'd2, "t5_mask_width", 16'h00FF);
      wr(3'd3, 16'h0000);
      wr(3'd7, 16'hFFFF);
      rd(3'd2, "t5_ro_ignored", 16'h00FF);
      rd(3'd7, "t5_reg7", 16'h0000);

      // 6: COUNT saturation via one fresh capture per cycle
      wr(3'd2, 16'h0000);
      wr(3'd5, 16'h0000);
      wr(3'd1, 16'hFFFF);
      wr(3'd6, 16'h0000);
      rd(3'd6, "t6_count_zero", 16'h0000);
      address = 3'd1; chipselect = 1'b1; write_n = 1'b0;
      for (int i = 0; i < 65534; i++) begin
         irq_in    = (i % 2 == 0) ? 8'h01 : 8'h02;
         writedata = (i % 2 == 0) ? 16'h0002 : 16'h0001;
         tick();
      end
      irq_in = 8'h00;
      rd(3'd6, "t6_count_fffe", 16'hFFFE);
      irq_in = 8'h01;
      tick();
      irq_in = 8'h00;
      rd(3'd6, "t6_count_ffff", 16'hFFFF);
      wr(3'd1, 16'h00FF);
      irq_in = 8'h01;
      tick();
      irq_in = 8'h00;
      rd(3'd6, "t6_count_sat", 16'hFFFF);

      // reset mid-pulse
      wr(3'd2, 16'h00FF);
      irq_in = 8'h01;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; irq_in = 8'h00;
      chk("t6_rst_irq", {15'b0, irq}, 16'h0);
      chk("t6_rst_rdata", readdata, 16'h0);
      for (int a = 0; a < 8; a++)
         rd(3'(a), $sformatf("t6_rst_reg%0d", a), (a == 5) ? ERST : 16'h0);

      // line high across reset release captured once in edge mode (bit 5)
      irq_in = 8'h20;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      rd(3'd1, "t6_rel_capture", 16'h0020);
      wr(3'd1, 16'h0020);
      rd(3'd1, "t6_rel_once", 16'h0000);
      rd(3'd6, "t6_rel_count", 16'h0001);
      irq_in = 8'h00;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
